// File: rtl/clock_divider_multi.sv
// Multi-channel programmable clock divider with per-channel run-time divisor reload.
// Define CLKDIV_TICK_EN to add the per-channel period-start tick output.
module clock_divider_multi #(
  parameter int NUM_CH      = 4,
  parameter int WIDTH       = 16,
  parameter int DEFAULT_DIV = 2,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock_in,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] enable,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [WIDTH-1:0]  cfg_div,
`ifdef CLKDIV_TICK_EN
  output logic [NUM_CH-1:0] tick,
`endif
  output logic [NUM_CH-1:0] clock_out
);

  logic              in_range;
  logic [NUM_CH-1:0] sel;
  logic [NUM_CH-1:0] pend_valid;
  logic [WIDTH-1:0]  cfg_div_clamped;

  // Writes aimed past the last channel are accepted and dropped.
  if ((1 << CH_W) > NUM_CH) begin : g_range_chk
    assign in_range = (cfg_ch < CH_W'(NUM_CH));
  end else begin : g_range_full
    assign in_range = 1'b1;
  end

  assign cfg_ready       = ~|(sel & pend_valid);
  assign cfg_div_clamped = (cfg_div < WIDTH'(2)) ? WIDTH'(2) : cfg_div;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] div_act;
    logic [WIDTH-1:0] pend_div;
    logic             pend_q;
    logic             clk_q;
    logic             accept;
    logic             period_end;

    assign sel[c]        = in_range && (cfg_ch == CH_W'(c));
    assign accept        = cfg_valid && cfg_ready && sel[c];
    assign period_end    = (cnt >= div_act - WIDTH'(1));
    assign pend_valid[c] = pend_q;
    assign clock_out[c]  = clk_q;

    // NOTE: pend_div is only read while pend_q is set, so it needs no reset.
    always_ff @(posedge clock_in) begin
      if (accept) pend_div <= cfg_div_clamped;
    end

    // NOTE: non-blocking assignments keep every right-hand side at its pre-edge value,
    // which is exactly what the clock_out/tick equations rely on.
    always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
        cnt     <= '0;
        div_act <= WIDTH'(DEFAULT_DIV);
        pend_q  <= 1'b0;
        clk_q   <= 1'b0;
      end else begin
        clk_q <= enable[c] & (cnt < (div_act >> 1));
        if (!enable[c] || period_end) begin
          cnt <= '0;
          if (pend_q) begin
            div_act <= pend_div;
            pend_q  <= 1'b0;
          end
        end else begin
          cnt <= cnt + WIDTH'(1);
        end
        // Ready is low while pending, so this never collides with the apply above.
        if (accept) pend_q <= 1'b1;
      end
    end

`ifdef CLKDIV_TICK_EN
    logic tick_q;
    assign tick[c] = tick_q;

    always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) tick_q <= 1'b0;
      else          tick_q <= enable[c] & (cnt == '0);
    end
`endif
  end

endmodule

// File: tb/tb_clock_divider_multi.sv
// Directed bench for clock_divider_multi: a 4-channel instance for the main scenarios,
// a 5-channel instance so that an out-of-range cfg_ch value is representable.
module tb_clock_divider_multi;

  localparam int WIDTH = 16;

  logic clock_in = 1'b0;
  logic reset_n  = 1'b0;
  always #5 clock_in = ~clock_in;

  logic [3:0]       enable;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [1:0]       cfg_ch;
  logic [WIDTH-1:0] cfg_div;
  logic [3:0]       clock_out;

  logic [4:0]       enable2;
  logic             cfg_valid2;
  logic             cfg_ready2;
  logic [2:0]       cfg_ch2;
  logic [WIDTH-1:0] cfg_div2;
  logic [4:0]       clock_out2;

`ifdef CLKDIV_TICK_EN
  logic [3:0] tick;
  logic [4:0] tick2;
`endif

  int checks = 0;
  int errors = 0;

  clock_divider_multi #(.NUM_CH(4), .WIDTH(WIDTH), .DEFAULT_DIV(2)) dut (
    .clock_in  (clock_in),
    .reset_n   (reset_n),
    .enable    (enable),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
`ifdef CLKDIV_TICK_EN
    .tick      (tick),
`endif
    .clock_out (clock_out)
  );

  clock_divider_multi #(.NUM_CH(5), .WIDTH(WIDTH), .DEFAULT_DIV(2)) dut2 (
    .clock_in  (clock_in),
    .reset_n   (reset_n),
    .enable    (enable2),
    .cfg_valid (cfg_valid2),
    .cfg_ready (cfg_ready2),
    .cfg_ch    (cfg_ch2),
    .cfg_div   (cfg_div2),
`ifdef CLKDIV_TICK_EN
    .tick      (tick2),
`endif
    .clock_out (clock_out2)
  );

  task automatic step();
    @(posedge clock_in);
    #1;
  endtask

  task automatic test_reset();
    enable = '0; cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0;
    enable2 = '0; cfg_valid2 = 1'b0; cfg_ch2 = '0; cfg_div2 = '0;
    step();
    step();
    checks++;
    if (clock_out !== 4'b0000) begin
      errors++; $display("FAIL reset_clock_out got %b expected 0000", clock_out);
    end
    checks++;
    if (cfg_ready !== 1'b1) begin
      errors++; $display("FAIL reset_cfg_ready got %b expected 1", cfg_ready);
    end
    checks++;
    if (clock_out2 !== 5'b00000) begin
      errors++; $display("FAIL reset_clock_out2 got %b expected 00000", clock_out2);
    end
`ifdef CLKDIV_TICK_EN
    checks++;
    if (tick !== 4'b0000) begin
      errors++; $display("FAIL reset_tick got %b expected 0000", tick);
    end
`endif
    #2 reset_n = 1'b1;
    step();
    checks++;
    if (clock_out !== 4'b0000) begin
      errors++; $display("FAIL idle_clock_out got %b expected 0000", clock_out);
    end
  endtask

  task automatic test_div2();
    logic [0:3] pat = 4'b1010;
    enable = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (clock_out !== {3'b000, pat[i]}) begin
        errors++; $display("FAIL div2_cycle%0d got %b expected %b", i, clock_out, {3'b000, pat[i]});
      end
`ifdef CLKDIV_TICK_EN
      checks++;
      if (tick !== {3'b000, pat[i]}) begin
        errors++; $display("FAIL div2_tick%0d got %b expected %b", i, tick, {3'b000, pat[i]});
      end
`endif
    end
    enable = 4'b0000;
    step();
    checks++;
    if (clock_out !== 4'b0000) begin
      errors++; $display("FAIL div2_disable got %b expected 0000", clock_out);
    end
  endtask

  task automatic test_div5();
    logic [0:9] pat  = 10'b1100011000;
    logic [0:9] tpat = 10'b1000010000;
    cfg_ch = 2'd1; cfg_div = 16'd5; cfg_valid = 1'b1;
    #1;
    checks++;
    if (cfg_ready !== 1'b1) begin
      errors++; $display("FAIL div5_ready_before got %b expected 1", cfg_ready);
    end
    step();
    cfg_valid = 1'b0;
    #1;
    checks++;
    if (cfg_ready !== 1'b0) begin
      errors++; $display("FAIL div5_ready_pending got %b expected 0", cfg_ready);
    end
    step();
    checks++;
    if (cfg_ready !== 1'b1) begin
      errors++; $display("FAIL div5_ready_applied got %b expected 1", cfg_ready);
    end
    enable = 4'b0010;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (clock_out !== {2'b00, pat[i], 1'b0}) begin
        errors++; $display("FAIL div5_cycle%0d got %b expected %b", i, clock_out, {2'b00, pat[i], 1'b0});
      end
`ifdef CLKDIV_TICK_EN
      checks++;
      if (tick !== {2'b00, tpat[i], 1'b0}) begin
        errors++; $display("FAIL div5_tick%0d got %b expected %b", i, tick, {2'b00, tpat[i], 1'b0});
      end
`endif
    end
    enable = 4'b0000;
    step();
  endtask

  task automatic test_reload_mid_period();
    // Four cycles at div 4, then div 6 periods.
    logic [0:15] pat = 16'b1100_111000_111000;
    cfg_ch = 2'd2; cfg_div = 16'd4; cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    step();
    enable = 4'b0100;
    for (int i = 0; i < 16; i++) begin
      step();
      checks++;
      if (clock_out !== {1'b0, pat[i], 2'b00}) begin
        errors++; $display("FAIL reload_cycle%0d got %b expected %b", i, clock_out, {1'b0, pat[i], 2'b00});
      end
      if (i == 0) begin
        cfg_ch = 2'd2; cfg_div = 16'd6; cfg_valid = 1'b1;
        #1;
        checks++;
        if (cfg_ready !== 1'b1) begin
          errors++; $display("FAIL reload_ready_idle got %b expected 1", cfg_ready);
        end
      end else if (i == 1 || i == 2) begin
        cfg_valid = 1'b0;
        #1;
        checks++;
        if (cfg_ready !== 1'b0) begin
          errors++; $display("FAIL reload_ready_pending%0d got %b expected 0", i, cfg_ready);
        end
      end else if (i == 3) begin
        checks++;
        if (cfg_ready !== 1'b1) begin
          errors++; $display("FAIL reload_ready_applied got %b expected 1", cfg_ready);
        end
      end
    end
    enable = 4'b0000;
    step();
  endtask

  task automatic test_back_to_back();
    logic [0:5] pat2 = 6'b110011;
    logic [0:5] pat3 = 6'b100100;
    cfg_ch = 2'd2; cfg_div = 16'd4; cfg_valid = 1'b1;
    step();
    cfg_div = 16'd8;
    #1;
    checks++;
    if (cfg_ready !== 1'b0) begin
      errors++; $display("FAIL b2b_second_write_ready got %b expected 0", cfg_ready);
    end
    step();
    cfg_ch = 2'd3; cfg_div = 16'd3;
    #1;
    checks++;
    if (cfg_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_ch3_ready got %b expected 1", cfg_ready);
    end
    step();
    cfg_valid = 1'b0;
    #1;
    checks++;
    if (cfg_ready !== 1'b0) begin
      errors++; $display("FAIL b2b_ch3_pending got %b expected 0", cfg_ready);
    end
    cfg_ch = 2'd2;
    #1;
    checks++;
    if (cfg_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_ch2_free got %b expected 1", cfg_ready);
    end
    step();
    enable = 4'b1100;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (clock_out !== {pat3[i], pat2[i], 2'b00}) begin
        errors++; $display("FAIL b2b_cycle%0d got %b expected %b", i, clock_out, {pat3[i], pat2[i], 2'b00});
      end
    end
    enable = 4'b0000;
    step();
  endtask

  task automatic test_clamp();
    logic [0:3] pat = 4'b1010;
    cfg_ch = 2'd0; cfg_div = 16'd0; cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    step();
    cfg_ch = 2'd1; cfg_div = 16'd1; cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    step();
    enable = 4'b0011;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (clock_out !== {2'b00, pat[i], pat[i]}) begin
        errors++; $display("FAIL clamp_cycle%0d got %b expected %b", i, clock_out, {2'b00, pat[i], pat[i]});
      end
    end
    enable = 4'b0000;
    step();
  endtask

  task automatic test_out_of_range();
    logic [0:3] pat = 4'b1010;
    cfg_ch2 = 3'd5; cfg_div2 = 16'd9; cfg_valid2 = 1'b1;
    #1;
    checks++;
    if (cfg_ready2 !== 1'b1) begin
      errors++; $display("FAIL oor_ready_ch5 got %b expected 1", cfg_ready2);
    end
    cfg_ch2 = 3'd7;
    #1;
    checks++;
    if (cfg_ready2 !== 1'b1) begin
      errors++; $display("FAIL oor_ready_ch7 got %b expected 1", cfg_ready2);
    end
    step();
    cfg_valid2 = 1'b0;
    for (int c = 0; c < 5; c++) begin
      cfg_ch2 = 3'(c);
      #1;
      checks++;
      if (cfg_ready2 !== 1'b1) begin
        errors++; $display("FAIL oor_untouched_ch%0d got %b expected 1", c, cfg_ready2);
      end
    end
    enable2 = 5'b11111;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (clock_out2 !== {5{pat[i]}}) begin
        errors++; $display("FAIL oor_cycle%0d got %b expected %b", i, clock_out2, {5{pat[i]}});
      end
    end
    enable2 = 5'b00000;
    step();
  endtask

  task automatic test_reset_mid();
    logic [0:3] pat = 4'b1010;
    cfg_ch = 2'd3; cfg_div = 16'd7; cfg_valid = 1'b1;
    enable = 4'b1001;
    step();
    checks++;
    if (clock_out !== 4'b1001) begin
      errors++; $display("FAIL rstmid_running got %b expected 1001", clock_out);
    end
    cfg_valid = 1'b0;
    #1;
    checks++;
    if (cfg_ready !== 1'b0) begin
      errors++; $display("FAIL rstmid_pending got %b expected 0", cfg_ready);
    end
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if (clock_out !== 4'b0000) begin
      errors++; $display("FAIL rstmid_async_clear got %b expected 0000", clock_out);
    end
    checks++;
    if (cfg_ready !== 1'b1) begin
      errors++; $display("FAIL rstmid_ready got %b expected 1", cfg_ready);
    end
`ifdef CLKDIV_TICK_EN
    checks++;
    if (tick !== 4'b0000) begin
      errors++; $display("FAIL rstmid_tick got %b expected 0000", tick);
    end
`endif
    #3 reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (clock_out !== {pat[i], 2'b00, pat[i]}) begin
        errors++; $display("FAIL rstmid_cycle%0d got %b expected %b", i, clock_out, {pat[i], 2'b00, pat[i]});
      end
    end
    enable = 4'b0000;
    step();
  endtask

  initial begin
    test_reset();
    test_div2();
    test_div5();
    test_reload_mid_period();
    test_back_to_back();
    test_clamp();
    test_out_of_range();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
